ram_march_bist: RTL and testbench
=================================

Name: ram_march_bist

Overview:
- Built-in self-test controller that sits directly upstream of the team's 16x4 synchronous RAM and drives its wrt/rd/cs/addr/data_in pins.
- Runs a March C- style sequence on start and compares the RAM's registered read data.
- Reports pass/fail, the first failing address and a saturating error count.
- Used in bring-up benches and as the power-on memory check in the top level.

Parameters:
- AW, 4, RAM address width (depth = 2**AW).
- DW, 4, RAM data width.
- EW, 8, error counter width.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  one-cycle request to run the test; sampled only in IDLE
- ram_dout  input  DW  RAM data_out; valid the cycle after ram_rd was high
- ram_cs  output  1  RAM chip select; 1 while busy
- ram_wrt  output  1  RAM write strobe
- ram_rd  output  1  RAM read strobe
- ram_addr  output  AW  RAM address
- ram_din  output  DW  RAM write data
- busy  output  1  test in progress
- done  output  1  one-cycle pulse at test end
- pass  output  1  1 = last test had zero mismatches; held until next start
- fail_addr  output  AW  address of first mismatch of last test
- err_cnt  output  EW  mismatch count of last test, saturates at 2**EW-1

Behaviour:
- Reset (rst=0, async): state=IDLE. All outputs are 0, including ram_* strobes, ram_addr, ram_din, pass, fail_addr and err_cnt.
- The block never drives the RAM's own reset.
- Data values: "0" = all-zeros DW; "1" = all-ones DW.
- IDLE: on start=1, at the next edge:
  - clear err_cnt, fail_addr and pass;
  - set busy=1 and enter M0 with addr=0.
  - start is ignored in any other state.
- M0 (ascending, w0): 1 cycle per address; ram_wrt=1, ram_din=0.
- M1 (ascending, r0 then w1): 2 cycles per address.
  - Cycle R: ram_rd=1.
  - Cycle W: ram_wrt=1, ram_din=1, and ram_dout is compared against expected 0 in the same cycle.
- M2 (descending from 2**AW-1, r1 then w0): same R/W pairing; expected value 1, write value 0.
- M3 (descending, r0): 2 cycles per address.
  - Cycle R: ram_rd=1.
  - Cycle C: all strobes 0; ram_dout compared against expected 0.
- Address counter behaviour:
  - Increments/decrements after the last cycle for each address.
  - Wraps to 0 (ascending) or 2**AW-1 (descending) when entering the next element.
  - No out-of-range address is ever driven.
- Compare rule:
  - A mismatch is any bit difference.
  - On mismatch, err_cnt increments, saturating with no wrap.
  - If err_cnt was 0, fail_addr captures the address whose read data is being compared.
- ram_cs=1 in all non-IDLE states; ram_wrt and ram_rd are never both 1.
- Latency with AW=4: M0 takes 16 cycles and M1/M2/M3 take 32 each, so busy is high for 112 cycles (7*2**AW in general).
- After the final M3 compare, the next edge:
  - busy=0, done=1 for one cycle;
  - pass = (err_cnt==0);
  - return to IDLE.
- pass, fail_addr and err_cnt hold until the next accepted start.
- Reset mid-test aborts immediately to the reset values; a subsequent start runs a full test from M0.
- start asserted in the same cycle that done is high is ignored (state is DONE, not IDLE).

Decomposition:
- Shared package holds:
  - state enum: IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, M3_R, M3_C, DONE;
  - the constants DATA_ZERO and DATA_ONE derived from DW;
  - the default AW/DW.
- One natural sub-module: bist_addr_cnt, an up/down AW-bit counter with load-to-first-address and last-address flag.

Test Plan:
- Fault-free RAM model, start pulse -> busy for 112 cycles, first ram_wrt at addr 0, first M2 read at addr 15; done pulse on cycle 113; pass=1, err_cnt=0.
- RAM bit 2 of addr 5 stuck-at-0 -> only the M2 r1 read fails; done with pass=0, fail_addr=5, err_cnt=1.
- RAM addr 9 stuck at 4'hF -> M1 r0 and M3 r0 fail; pass=0, fail_addr=9, err_cnt=2.
- RAM faults at addr 3 (stuck-at-1, bit 0) and addr 12 (stuck-at-0, bit 3) -> fail_addr=3 (first, ascending M1), err_cnt=3.
- start pulsed again at cycle 40 of a run -> ignored, total run still 112 cycles; start in the same cycle as done -> ignored.
- rst=0 during M2 -> all outputs 0 asynchronously, ram_cs=0; rst released, start -> full clean run, pass=1.

Source files
------------

// File: rtl/ram_march_bist_pkg.sv
// Shared types and constants for the March C- RAM self-test controller.
package ram_march_bist_pkg;

  localparam int DEF_AW = 4;
  localparam int DEF_DW = 4;

  localparam logic [DEF_DW-1:0] DATA_ZERO = '0;
  localparam logic [DEF_DW-1:0] DATA_ONE  = '1;

  typedef enum logic [3:0] {
    IDLE,
    M0_W,
    M1_R,
    M1_W,
    M2_R,
    M2_W,
    M3_R,
    M3_C,
    DONE
  } state_e;

endpackage

// File: rtl/ram_march_bist_addr_cnt.sv
// Up/down address counter for the march elements: loads the first address of
// an element and flags the last address in the current direction.
module bist_addr_cnt #(
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_i,
  input  logic          load_dn_i,
  input  logic          step_i,
  input  logic          dn_i,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_d;

  always_comb begin
    addr_d = addr_q;
    if (load_i) begin
      addr_d = load_dn_i ? '1 : '0;
    end else if (step_i) begin
      addr_d = dn_i ? (addr_q - AW'(1)) : (addr_q + AW'(1));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = dn_i ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/ram_march_bist.sv
// March C- self-test controller driving a synchronous RAM directly; reports
// pass/fail, the first failing address and a saturating mismatch count.
module ram_march_bist
  import ram_march_bist_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int EW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_cs,
  output logic          ram_wrt,
  output logic          ram_rd,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [EW-1:0] err_cnt
);

  localparam logic [DW-1:0] D_ZERO = {DW{DATA_ZERO[0]}};
  localparam logic [DW-1:0] D_ONE  = {DW{DATA_ONE[0]}};

  state_e        state_q, state_d;
  logic          cnt_load, cnt_load_dn, cnt_step, cnt_dn, cnt_last;
  logic [AW-1:0] cnt_addr;
  logic          cmp_en;
  logic [DW-1:0] cmp_exp;
  logic          pass_q, pass_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [EW-1:0] err_cnt_q, err_cnt_d;

  bist_addr_cnt #(.AW(AW)) u_addr_cnt (
    .clk_i    (clk),
    .rst_ni   (rst),
    .load_i   (cnt_load),
    .load_dn_i(cnt_load_dn),
    .step_i   (cnt_step),
    .dn_i     (cnt_dn),
    .addr_o   (cnt_addr),
    .last_o   (cnt_last)
  );

  // Direction depends only on the element, so the last flag never loops back.
  assign cnt_dn = (state_q == M2_R) || (state_q == M2_W) ||
                  (state_q == M3_R) || (state_q == M3_C);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_load    = 1'b0;
    cnt_load_dn = 1'b0;
    cnt_step    = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d  = M0_W;
        cnt_load = 1'b1;
      end
      M0_W: begin
        if (cnt_last) begin
          state_d  = M1_R;
          cnt_load = 1'b1;
        end else begin
          cnt_step = 1'b1;
        end
      end
      M1_R: state_d = M1_W;
      M1_W: begin
        if (cnt_last) begin
          state_d     = M2_R;
          cnt_load    = 1'b1;
          cnt_load_dn = 1'b1;
        end else begin
          state_d  = M1_R;
          cnt_step = 1'b1;
        end
      end
      M2_R: state_d = M2_W;
      M2_W: begin
        if (cnt_last) begin
          state_d     = M3_R;
          cnt_load    = 1'b1;
          cnt_load_dn = 1'b1;
        end else begin
          state_d  = M2_R;
          cnt_step = 1'b1;
        end
      end
      M3_R: state_d = M3_C;
      // The counter holds on the final compare, leaving address 0 in DONE.
      M3_C: begin
        if (cnt_last) begin
          state_d = DONE;
        end else begin
          state_d  = M3_R;
          cnt_step = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ram_wrt = 1'b0;
    ram_rd  = 1'b0;
    ram_din = D_ZERO;
    done    = 1'b0;
    cmp_en  = 1'b0;
    cmp_exp = D_ZERO;
    case (state_q)
      M0_W: ram_wrt = 1'b1;
      M1_R: ram_rd = 1'b1;
      M1_W: begin
        ram_wrt = 1'b1;
        ram_din = D_ONE;
        cmp_en  = 1'b1;
      end
      M2_R: ram_rd = 1'b1;
      M2_W: begin
        ram_wrt = 1'b1;
        cmp_en  = 1'b1;
        cmp_exp = D_ONE;
      end
      M3_R: ram_rd = 1'b1;
      M3_C: cmp_en = 1'b1;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign ram_cs   = (state_q != IDLE);
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign ram_addr = (state_q == IDLE) ? '0 : cnt_addr;

  // The RAM returns read data one cycle late, so the compare runs in the
  // cycle after the read strobe, while the address still points at it.
  always_comb begin
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    err_cnt_d   = err_cnt_q;
    if ((state_q == IDLE) && start) begin
      pass_d      = 1'b0;
      fail_addr_d = '0;
      err_cnt_d   = '0;
    end
    if (cmp_en && (ram_dout != cmp_exp)) begin
      if (err_cnt_q == '0) begin
        fail_addr_d = cnt_addr;
      end
      if (err_cnt_q != '1) begin
        err_cnt_d = err_cnt_q + EW'(1);
      end
    end
    if ((state_q == M3_C) && cnt_last) begin
      pass_d = (err_cnt_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: a 16x4 RAM with injectable stuck-at faults, an
// operation-level March C- model feeding an expected queue, and directed runs.
module tb_ram_march_bist;

  localparam int W = 26;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] ram_dout;
  logic       ram_cs, ram_wrt, ram_rd;
  logic [3:0] ram_addr, ram_din;
  logic       busy, done, pass;
  logic [3:0] fail_addr;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0]  exp_q[$];
  logic [12:0]   last_res = '0;
  logic [3:0]    ram_mem[16];
  logic [3:0]    and_m[16];
  logic [3:0]    or_m[16];
  logic [3:0]    m_fa;
  logic [7:0]    m_err;

  ram_march_bist dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ram_dout (ram_dout),
    .ram_cs   (ram_cs),
    .ram_wrt  (ram_wrt),
    .ram_rd   (ram_rd),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .fail_addr(fail_addr),
    .err_cnt  (err_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- RAM with stuck-at faults on the read path ----------------
  always @(posedge clk) begin
    if (ram_cs && ram_wrt) ram_mem[ram_addr] <= ram_din;
    if (ram_cs && ram_rd) ram_dout <= (ram_mem[ram_addr] & and_m[ram_addr]) | or_m[ram_addr];
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic clear_faults();
    for (int i = 0; i < 16; i++) begin
      and_m[i] = 4'hF;
      or_m[i]  = 4'h0;
    end
  endtask

  // ---------------- operation-level March C- model ----------------
  task automatic push(input logic wrt, input logic rd, input logic [3:0] a, input logic [3:0] d,
                      input logic busy_e, input logic done_e, input logic pass_e);
    exp_q.push_back({pass_e, m_fa, m_err, 1'b1, wrt, rd, a, d, busy_e, done_e});
  endtask

  task automatic model_cmp(input logic [3:0] got, input logic [3:0] expv, input logic [3:0] a);
    if (got !== expv) begin
      if (m_err == 8'd0) m_fa = a;
      if (m_err != 8'hFF) m_err++;
    end
  endtask

  task automatic build_model();
    logic [3:0] mem[16];
    logic [3:0] rv;
    m_fa  = 4'd0;
    m_err = 8'd0;
    for (int a = 0; a < 16; a++) begin
      push(1'b1, 1'b0, 4'(a), 4'h0, 1'b1, 1'b0, 1'b0);
      mem[a] = 4'h0;
    end
    for (int a = 0; a < 16; a++) begin
      push(1'b0, 1'b1, 4'(a), 4'h0, 1'b1, 1'b0, 1'b0);
      rv = (mem[a] & and_m[a]) | or_m[a];
      push(1'b1, 1'b0, 4'(a), 4'hF, 1'b1, 1'b0, 1'b0);
      model_cmp(rv, 4'h0, 4'(a));
      mem[a] = 4'hF;
    end
    for (int a = 15; a >= 0; a--) begin
      push(1'b0, 1'b1, 4'(a), 4'h0, 1'b1, 1'b0, 1'b0);
      rv = (mem[a] & and_m[a]) | or_m[a];
      push(1'b1, 1'b0, 4'(a), 4'h0, 1'b1, 1'b0, 1'b0);
      model_cmp(rv, 4'hF, 4'(a));
      mem[a] = 4'h0;
    end
    for (int a = 15; a >= 0; a--) begin
      push(1'b0, 1'b1, 4'(a), 4'h0, 1'b1, 1'b0, 1'b0);
      rv = (mem[a] & and_m[a]) | or_m[a];
      push(1'b0, 1'b0, 4'(a), 4'h0, 1'b1, 1'b0, 1'b0);
      model_cmp(rv, 4'h0, 4'(a));
    end
    push(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, (m_err == 8'd0));
  endtask

  // ---------------- scoreboard: every negedge ----------------
  always @(negedge clk) begin
    logic [W-1:0] act, e;
    act = {pass, fail_addr, err_cnt, ram_cs, ram_wrt, ram_rd, ram_addr, ram_din, busy, done};
    if (!rst) begin
      exp_q.delete();
      last_res = '0;
      check("reset_outputs", 32'(act), 32'd0);
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e[0]) last_res = e[25:13];
      check("cycle", 32'(act), 32'(e));
    end else begin
      check("idle", 32'(act), 32'({last_res, 13'd0}));
    end
  end

  // ---------------- driver ----------------
  task automatic do_run(input int mid_start, input bit start_at_done, input int abort_cyc,
                        output int busy_cnt, output int done_cyc);
    busy_cnt = 0;
    done_cyc = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    build_model();
    for (int c = 1; c <= 200; c++) begin
      if (c == 1) check("first_write_addr0", 32'({ram_wrt, ram_rd, ram_addr}), 32'b10_0000);
      if (c == 49) check("first_m2_read_addr15", 32'({ram_rd, ram_wrt, ram_addr}), 32'b10_1111);
      if (c == abort_cyc) begin
        #2 rst = 1'b0;
        #1 check("async_reset_abort",
                 32'({pass, fail_addr, err_cnt, ram_cs, ram_wrt, ram_rd, ram_addr, ram_din, busy, done}),
                 32'd0);
        return;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cyc = c;
        if (start_at_done) begin
          start = 1'b1;
          @(posedge clk); #1 start = 1'b0;
          check("start_at_done_ignored", 32'({busy, ram_cs}), 32'd0);
        end
        break;
      end
      start = (c == mid_start);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_res(input string name, input logic p, input logic [3:0] fa, input logic [7:0] ec);
    check(name, 32'({pass, fail_addr, err_cnt}), 32'({p, fa, ec}));
  endtask

  initial begin
    int bc, dc;
    rst   = 1'b1;
    start = 1'b0;
    clear_faults();
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // clean RAM
    do_run(0, 1'b0, 0, bc, dc);
    check("t1_busy_cycles", bc, 112);
    check("t1_done_cycle", dc, 113);
    check_res("t1_result", 1'b1, 4'd0, 8'd0);
    repeat (3) @(posedge clk);

    // addr 5 bit 2 stuck-at-0
    and_m[5] = 4'hB;
    do_run(0, 1'b0, 0, bc, dc);
    check("t2_done_cycle", dc, 113);
    check_res("t2_result", 1'b0, 4'd5, 8'd1);
    clear_faults();
    repeat (3) @(posedge clk);

    // addr 9 stuck at all-ones
    or_m[9] = 4'hF;
    do_run(0, 1'b0, 0, bc, dc);
    check_res("t3_result", 1'b0, 4'd9, 8'd2);
    clear_faults();
    repeat (3) @(posedge clk);

    // addr 3 bit 0 stuck-at-1, addr 12 bit 3 stuck-at-0
    or_m[3]   = 4'h1;
    and_m[12] = 4'h7;
    do_run(0, 1'b0, 0, bc, dc);
    check_res("t4_result", 1'b0, 4'd3, 8'd3);
    clear_faults();
    repeat (3) @(posedge clk);

    // start mid-run and start during the done cycle are both ignored
    do_run(40, 1'b1, 0, bc, dc);
    check("t5_busy_cycles", bc, 112);
    check("t5_done_cycle", dc, 113);
    check_res("t5_result", 1'b1, 4'd0, 8'd0);
    repeat (3) @(posedge clk);

    // reset in the middle of M2, then a full clean run
    do_run(0, 1'b0, 60, bc, dc);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check_res("t6_after_reset", 1'b0, 4'd0, 8'd0);
    do_run(0, 1'b0, 0, bc, dc);
    check("t6_busy_cycles", bc, 112);
    check("t6_done_cycle", dc, 113);
    check_res("t6_result", 1'b1, 4'd0, 8'd0);
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
